// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: access sizes, FSM states and the
// store-side lane helpers.
package mem_access_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Reserved size code 2'b11 behaves as a word everywhere.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    logic m;
    m = 1'b0;
    case (size)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = a[0];
      default: m = (a != 2'b00);
    endcase
    return m;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = 4'b0001 << a;
      SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] d;
    d = 32'd0;
    case (size)
      SZ_BYTE: d = {4{wd[7:0]}};
      SZ_HALF: d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_stage_load_align.sv
// Load lane select and sign/zero extension; purely combinational so the
// cache fill path can share it.
module load_align
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  a,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed lane, then widen it.
  always_comb begin
    byte_s = 8'd0;
    data   = 32'd0;
    case (a)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = 8'd0;
    endcase
    half_s = a[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: data = uns ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
      SZ_HALF: data = uns ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
      default: data = rdata;
    endcase
  end
endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data bus for loads/stores, stalls upstream
// while an access is outstanding and forwards results to MEM/WB.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic [1:0]         MemSize,
  input  logic               MemUnsigned,
  input  logic [2:0]         WB,
  input  logic [31:0]        ALUresult,
  input  logic [31:0]        WriteData,
  input  logic [4:0]         Rd,
  input  logic [31:0]        PCplus,
  mem_access_stage_if.master bus,
  output logic               stall,
  output logic               bus_fault,
  output logic [2:0]         WB_out,
  output logic [31:0]        MemData_out,
  output logic [31:0]        ALUresult_out,
  output logic [4:0]         Rd_out,
  output logic [31:0]        PCplus_out
);
  state_e            state_r, state_nx_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              kill_r, bus_fault_r, req_r, we_r;
  logic [31:0]       addr_r, wdata_r, mem_data_r, ld_data_s;
  logic [3:0]        be_r;
  logic              mop_s, misalign_s, start_s, ack_s, timeout_s, fault_s;

  assign mop_s      = valid & (MemRead | MemWrite);
  assign misalign_s = misaligned(MemSize, ALUresult[1:0]);

  load_align u_load_align (
    .rdata (bus.mem_rdata),
    .a     (ALUresult[1:0]),
    .size  (MemSize),
    .uns   (MemUnsigned),
    .data  (ld_data_s)
  );

  // Next state and the events that steer the registers.
  always_comb begin
    state_nx_s = state_r;
    start_s    = 1'b0;
    ack_s      = 1'b0;
    timeout_s  = 1'b0;
    fault_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mop_s && !misalign_s) begin
          state_nx_s = ST_BUSY;
          start_s    = 1'b1;
        end else if (mop_s) begin
          fault_s = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // An ack arriving on the last allowed cycle still completes normally.
        if (bus.mem_ack) begin
          state_nx_s = ST_DONE;
          ack_s      = 1'b1;
        end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
          state_nx_s = ST_DONE;
          timeout_s  = 1'b1;
        end else begin
          state_nx_s = ST_BUSY;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State, timeout counter, bus request and load-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      kill_r      <= 1'b0;
      bus_fault_r <= 1'b0;
      req_r       <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      be_r        <= 4'd0;
      mem_data_r  <= 32'd0;
    end else begin
      state_r     <= state_nx_s;
      bus_fault_r <= fault_s | timeout_s;
      if (start_s) begin
        req_r      <= 1'b1;
        we_r       <= MemWrite & ~MemRead;
        addr_r     <= {ALUresult[31:2], 2'b00};
        wdata_r    <= store_data(MemSize, WriteData);
        be_r       <= byte_en(MemSize, ALUresult[1:0]);
        cnt_r      <= {CNT_W{1'b0}};
        mem_data_r <= 32'd0;
      end else if (ack_s) begin
        req_r      <= 1'b0;
        mem_data_r <= MemRead ? ld_data_s : 32'd0;
      end else if (timeout_s) begin
        req_r  <= 1'b0;
        kill_r <= 1'b1;
      end else if (state_r == ST_BUSY) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else if (state_r == ST_DONE) begin
        kill_r <= 1'b0;
      end
    end
  end

  // Stall and MEM/WB-facing outputs; WB is bubbled while stalled.
  always_comb begin
    stall       = 1'b0;
    WB_out      = WB;
    MemData_out = 32'd0;
    case (state_r)
      ST_IDLE: begin
        if (mop_s && !misalign_s) begin
          stall  = rst_n;
          WB_out = 3'd0;
        end else if (mop_s) begin
          WB_out = 3'd0;
        end else begin
          WB_out = WB;
        end
      end
      ST_BUSY: begin
        stall  = 1'b1;
        WB_out = 3'd0;
      end
      ST_DONE: begin
        MemData_out = mem_data_r;
        WB_out      = kill_r ? 3'd0 : WB;
      end
      default: begin
        stall  = 1'b0;
        WB_out = 3'd0;
      end
    endcase
  end

  assign bus.mem_req    = req_r;
  assign bus.mem_we     = we_r;
  assign bus.mem_addr   = addr_r;
  assign bus.mem_wdata  = wdata_r;
  assign bus.mem_be     = be_r;
  assign bus_fault      = bus_fault_r;
  assign ALUresult_out  = ALUresult;
  assign Rd_out         = Rd;
  assign PCplus_out     = PCplus;
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: driver pushes expected bus requests
// and retirements, a negedge monitor pops and compares them.
module tb_mem_access_stage;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid, MemRead, MemWrite, MemUnsigned;
  logic [1:0]  MemSize;
  logic [2:0]  WB;
  logic [31:0] ALUresult, WriteData, PCplus;
  logic [4:0]  Rd;
  logic        stall, bus_fault;
  logic [2:0]  WB_out;
  logic [31:0] MemData_out, ALUresult_out, PCplus_out;
  logic [4:0]  Rd_out;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]  wb;
    logic [31:0] md, alu, pc;
    logic [4:0]  rd;
    int          stalls;
    bit          timeout, misalign;
  } ret_t;

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    int          busy;
  } bus_t;

  ret_t ret_q[$];
  bus_t bus_q[$];

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid         (valid),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .MemSize       (MemSize),
    .MemUnsigned   (MemUnsigned),
    .WB            (WB),
    .ALUresult     (ALUresult),
    .WriteData     (WriteData),
    .Rd            (Rd),
    .PCplus        (PCplus),
    .bus           (bus),
    .stall         (stall),
    .bus_fault     (bus_fault),
    .WB_out        (WB_out),
    .MemData_out   (MemData_out),
    .ALUresult_out (ALUresult_out),
    .Rd_out        (Rd_out),
    .PCplus_out    (PCplus_out)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: shift the addressed naturally-aligned lane down, mask, extend.
  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [1:0] a,
                                           input int nb, input logic uns);
    logic [63:0] v, mask;
    int sh;
    sh   = 8 * (int'(a) - (int'(a) % nb));
    mask = (64'd1 << (8 * nb)) - 64'd1;
    v    = ({32'd0, rdata} >> sh) & mask;
    if (!uns && v[8*nb-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] a, input int nb);
    logic [7:0] full;
    full = ((8'd1 << nb) - 8'd1) << (int'(a) - (int'(a) % nb));
    return full[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input int nb);
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % nb) +: 8];
    return w;
  endfunction

  int   mon_stall_cnt, mon_req_cnt, mon_busy;
  bit   mon_pend, mon_prev_req, mon_exp_fault, mon_pend_nx;
  ret_t mon_e;
  bus_t mon_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_stall_cnt = 0;
      mon_req_cnt   = 0;
      mon_pend      = 1'b0;
      mon_prev_req  = 1'b0;
    end else begin
      if (bus.mem_req && !mon_prev_req) begin
        if (bus_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_req: got mem_req addr %h expected no request", bus.mem_addr);
        end else begin
          mon_b = bus_q.pop_front();
          check("req_we", 32'(bus.mem_we), 32'(mon_b.we));
          check("req_addr", bus.mem_addr, mon_b.addr);
          if (mon_b.we) begin
            check("req_be", 32'(bus.mem_be), 32'(mon_b.be));
            check("req_wdata", bus.mem_wdata, mon_b.wdata);
          end
          mon_busy = mon_b.busy;
        end
        mon_req_cnt = 1;
      end else if (bus.mem_req) begin
        mon_req_cnt++;
      end else if (mon_prev_req) begin
        check("req_len", 32'(mon_req_cnt), 32'(mon_busy));
      end
      mon_prev_req = bus.mem_req;

      mon_exp_fault = mon_pend;
      mon_pend_nx   = 1'b0;
      if (stall) mon_stall_cnt++;
      if (valid && !stall) begin
        if (ret_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_retire: got retire alu %h expected none", ALUresult_out);
        end else begin
          mon_e = ret_q.pop_front();
          check("wb_out", 32'(WB_out), 32'(mon_e.wb));
          check("memdata", MemData_out, mon_e.md);
          check("alu_out", ALUresult_out, mon_e.alu);
          check("rd_out", 32'(Rd_out), 32'(mon_e.rd));
          check("pc_out", PCplus_out, mon_e.pc);
          check("stall_cycles", 32'(mon_stall_cnt), 32'(mon_e.stalls));
          mon_exp_fault = mon_exp_fault | mon_e.timeout;
          mon_pend_nx   = mon_e.misalign;
        end
        mon_stall_cnt = 0;
      end
      check("bus_fault", 32'(bus_fault), 32'(mon_exp_fault));
      mon_pend = mon_pend_nx;
    end
  end

  // Drive one instruction (called just after a posedge) and act as memory until it retires.
  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                       input int delay);
    ret_t r;
    bus_t b;
    int   nb, busy, cnt;
    bit   mop, mis, to, retired;
    valid = 1'b1; MemRead = rd; MemWrite = wr; MemSize = sz; MemUnsigned = uns;
    ALUresult = addr; WriteData = wd;
    WB = 3'($urandom); Rd = 5'($urandom); PCplus = $urandom;
    nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    mop  = rd || wr;
    mis  = mop && ((addr % 32'(nb)) != 32'd0);
    to   = mop && !mis && !(delay >= 1 && delay <= TIMEOUT);
    busy = (delay >= 1 && delay <= TIMEOUT) ? delay : TIMEOUT;
    r.wb       = (mis || to) ? 3'd0 : WB;
    r.md       = (rd && !mis && !to) ? ref_load(rdata, addr[1:0], nb, uns) : 32'd0;
    r.alu      = addr;
    r.rd       = Rd;
    r.pc       = PCplus;
    r.stalls   = (mop && !mis) ? 1 + busy : 0;
    r.timeout  = to;
    r.misalign = mis;
    ret_q.push_back(r);
    if (mop && !mis) begin
      b.we    = wr && !rd;
      b.addr  = addr & 32'hFFFF_FFFC;
      b.be    = ref_be(addr[1:0], nb);
      b.wdata = ref_wdata(wd, nb);
      b.busy  = busy;
      bus_q.push_back(b);
    end
    retired = 1'b0;
    cnt = 0;
    for (int c = 0; c < 2 * TIMEOUT + 8 && !retired; c++) begin
      @(negedge clk);
      retired = !stall;
      if (bus.mem_req) begin
        cnt++;
        bus.mem_ack   = (cnt == delay);
        bus.mem_rdata = (cnt == delay) ? rdata : $urandom;
      end else begin
        bus.mem_ack   = ($urandom_range(0, 3) == 0);
        bus.mem_rdata = $urandom;
      end
      @(posedge clk); #1;
    end
    if (!retired) check("retire_bound", 32'd0, 32'd1);
  endtask

  task automatic gap(input int n);
    valid = 1'b0; ALUresult = $urandom;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      bus.mem_ack   = ($urandom_range(0, 3) == 0);
      bus.mem_rdata = $urandom;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus_t        b;
    logic        rd, wr, uns;
    logic [1:0]  sz;
    logic [31:0] addr;
    int          kind, delay;
    valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemSize = 2'b00; MemUnsigned = 1'b0;
    WB = 3'd0; ALUresult = 32'd0; WriteData = 32'd0; Rd = 5'd0; PCplus = 32'd0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(bus.mem_req), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_be", 32'(bus.mem_be), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_fault", 32'(bus_fault), 32'd0);
    check("rst_memdata", MemData_out, 32'd0);
    rst_n = 1'b1;

    issue(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'd0, 32'd0, 1);
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'd0, 32'h80FF_FF7F, 2);
    issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'd0, 32'h80FF_FF7F, 2);
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'd0, 1);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'd0, 32'd0, 1);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'd0, 32'h1111_2222, 0);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0304, 32'd0, 32'h3333_4444, TIMEOUT);

    // Abandon an access mid-flight with an asynchronous reset.
    valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; MemSize = 2'b10; ALUresult = 32'h0000_0400;
    bus.mem_ack = 1'b0;
    b.we = 1'b0; b.addr = 32'h0000_0400; b.be = 4'hF; b.wdata = 32'd0; b.busy = TIMEOUT;
    bus_q.push_back(b);
    @(posedge clk); @(posedge clk); #2;
    check("pre_rst_req", 32'(bus.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(bus.mem_req), 32'd0);
    check("async_rst_stall", 32'(stall), 32'd0);
    valid = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'd0, 32'hCAFE_F00D, 3);

    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 9);
      rd   = (kind < 4) || (kind == 9);
      wr   = (kind >= 4 && kind < 7) || (kind == 9);
      sz   = 2'($urandom);
      uns  = 1'($urandom);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) addr[0] = 1'b0;
        else if (sz[1]) addr[1:0] = 2'b00;
      end
      delay = ($urandom_range(0, 9) == 0) ? 0 :
              ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(1, 5);
      issue(rd, wr, sz, uns, addr, $urandom, $urandom, delay);
      if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 3));
    end

    gap(3);
    check("ret_q_empty", 32'(ret_q.size()), 32'd0);
    check("bus_q_empty", 32'(bus_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
